// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ADD/ADDI/BNE control sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StDecode,
    StExecute,
    StWriteback
  } state_e;

  // Instruction kind resolved from the latched IR
  typedef enum logic [1:0] {
    KindIllegal,
    KindAdd,
    KindAddi,
    KindBne
  } kind_e;

  localparam logic [6:0] OpcodeOp   = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm = 7'b0010011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  localparam logic [2:0] F3Add = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;
  localparam logic [6:0] F7Add = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  function automatic kind_e decode_kind(input logic [31:0] ir);
    kind_e kind;
    kind = KindIllegal;
    if (ir[6:0] == OpcodeOp && ir[14:12] == F3Add && ir[31:25] == F7Add) begin
      kind = KindAdd;
    end else if (ir[6:0] == OpcodeOpImm && ir[14:12] == F3Add) begin
      kind = KindAddi;
    end else if (ir[6:0] == OpcodeBranch && ir[14:12] == F3Bne) begin
      kind = KindBne;
    end
    return kind;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction: I-type for ADDI, B-type for BNE, zero for everything else.
module imm_gen
  import alu_seq_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [11:0]          ir_hi_i,  // IR[31:20]
  input  logic [4:0]           ir_lo_i,  // IR[11:7]
  input  kind_e                kind_i,
  output logic [DataWidth-1:0] imm_o
);

  logic [11:0] imm_itype;
  logic [12:0] imm_btype;

  assign imm_itype = ir_hi_i;
  // {IR[31], IR[7], IR[30:25], IR[11:8], 0}
  assign imm_btype = {ir_hi_i[11], ir_lo_i[0], ir_hi_i[10:5], ir_lo_i[4:1], 1'b0};

  // Sign-extend the field selected by the instruction kind
  always_comb begin
    imm_o = '0;
    case (kind_i)
      KindAddi: imm_o = {{(DataWidth - 12){imm_itype[11]}}, imm_itype};
      KindBne:  imm_o = {{(DataWidth - 13){imm_btype[12]}}, imm_btype};
      default:  imm_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving the regfile/ALU datapath.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned           Data_Width = 32,
  parameter int unsigned           Addr_Width = 5,
  parameter logic [Data_Width-1:0] Reset_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [Data_Width-1:0] instr,
  output logic [Data_Width-1:0] PC,
  output logic [Addr_Width-1:0] rs1,
  output logic [Addr_Width-1:0] rs2,
  output logic [Addr_Width-1:0] rd,
  output logic [Data_Width-1:0] ImmOp,
  output logic                  ALUSrc,
  output logic [2:0]            ALUctrl,
  input  logic                  EQ,
  output logic                  RegWrite,
  output logic                  instr_done,
  output logic                  illegal
);

  localparam logic [Data_Width-1:0] PcStep = Data_Width'(4);

  state_e                state_q, state_d;
  logic [Data_Width-1:0] ir_q, ir_d;
  logic [Data_Width-1:0] pc_q, pc_d;
  logic                  taken_q, taken_d;
  logic [Data_Width-1:0] imm;
  kind_e                 kind;

  assign kind = decode_kind(ir_q[31:0]);

  imm_gen #(
    .DataWidth(Data_Width)
  ) u_imm_gen (
    .ir_hi_i(ir_q[31:20]),
    .ir_lo_i(ir_q[11:7]),
    .kind_i (kind),
    .imm_o  (imm)
  );

  // State, IR, PC and branch-outcome registers; reset discards any in-flight PC update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ir_q    <= '0;
      pc_q    <= Reset_PC;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  // Next-state: fixed walk through the phases, IR load on ack, PC update on WB exit
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        // EQ is only meaningful while the ALU is doing the BNE compare
        taken_d = (kind == KindBne) && !EQ;
        state_d = StWriteback;
      end
      StWriteback: begin
        pc_d    = taken_q ? pc_q + imm : pc_q + PcStep;
        taken_d = 1'b0;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign PC = pc_q;

  // Moore outputs from state and IR; operand fields held from DECODE to WRITEBACK
  always_comb begin
    imem_req   = 1'b0;
    rs1        = '0;
    rs2        = '0;
    rd         = '0;
    ImmOp      = '0;
    ALUSrc     = 1'b0;
    ALUctrl    = ALU_ADD;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (state_q == StFetch) begin
      // Held low while reset is applied
      imem_req = rst_n;
    end else begin
      rs1     = Addr_Width'(ir_q[19:15]);
      rs2     = Addr_Width'(ir_q[24:20]);
      rd      = Addr_Width'(ir_q[11:7]);
      ImmOp   = imm;
      ALUSrc  = (kind == KindAddi);
      ALUctrl = (kind == KindBne) ? ALU_SUB : ALU_ADD;
      if (state_q == StWriteback) begin
        RegWrite   = ((kind == KindAdd) || (kind == KindAddi)) && (ir_q[11:7] != 5'd0);
        instr_done = 1'b1;
        illegal    = (kind == KindIllegal);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, reset corner cases, random stream.
module tb_alu_sequencer;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic        EQ = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_req;
  logic [31:0] PC;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic        ALUSrc;
  logic [2:0]  ALUctrl;
  logic        RegWrite, instr_done, illegal;

  always #5 clk = ~clk;

  alu_sequencer #(
    .Data_Width(32),
    .Addr_Width(5),
    .Reset_PC  (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .instr     (instr),
    .PC        (PC),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .ImmOp     (ImmOp),
    .ALUSrc    (ALUSrc),
    .ALUctrl   (ALUctrl),
    .EQ        (EQ),
    .RegWrite  (RegWrite),
    .instr_done(instr_done),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] ins;
    logic        eq;
    int          waits;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        alusrc;
    logic [2:0]  aluctrl;
    logic        regwrite;
    logic        ill;
    logic [31:0] off;  // added to PC at retirement
  } vec_t;

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;
  vec_t        tbl[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic eq, input int waits,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdx,
                              input logic [31:0] imm, input logic alusrc, input logic [2:0] ctrl,
                              input logic rw, input logic ill, input logic [31:0] off);
    vec_t v;
    v.ins = ins; v.eq = eq; v.waits = waits;
    v.rs1 = r1; v.rs2 = r2; v.rd = rdx;
    v.imm = imm; v.alusrc = alusrc; v.aluctrl = ctrl;
    v.regwrite = rw; v.ill = ill; v.off = off;
    return v;
  endfunction

  // Reference: instruction semantics from the ISA rules, immediates by plain arithmetic
  function automatic vec_t model(input logic [31:0] ins, input logic eq, input int waits);
    vec_t v;
    int   imm_val;
    bit   is_add, is_addi, is_bne;
    is_add  = ins[6:0] == 7'b0110011 && ins[14:12] == 3'd0 && ins[31:25] == 7'd0;
    is_addi = ins[6:0] == 7'b0010011 && ins[14:12] == 3'd0;
    is_bne  = ins[6:0] == 7'b1100011 && ins[14:12] == 3'd1;
    imm_val = 0;
    if (is_addi) begin
      imm_val = int'(ins[31:20]);
      if (imm_val >= 2048) imm_val -= 4096;
    end
    if (is_bne) begin
      imm_val = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
      if (imm_val >= 4096) imm_val -= 8192;
    end
    v.ins = ins; v.eq = eq; v.waits = waits;
    v.rs1 = ins[19:15]; v.rs2 = ins[24:20]; v.rd = ins[11:7];
    v.imm = 32'(imm_val);
    v.alusrc = is_addi;
    v.aluctrl = is_bne ? 3'd1 : 3'd0;
    v.regwrite = (is_add || is_addi) && (ins[11:7] != 5'd0);
    v.ill = !(is_add || is_addi || is_bne);
    v.off = (is_bne && !eq) ? v.imm : 32'd4;
    return v;
  endfunction

  // Runs one instruction starting in the first FETCH cycle; ack is pulsed in EXECUTE to
  // show it is ignored, and EQ is flipped in WRITEBACK to show it was sampled earlier.
  task automatic run_instr(input vec_t v, input string tag);
    for (int i = 0; i < v.waits; i++) begin
      imem_ack = 1'b0;
      instr = $urandom();
      chk({tag, " wait_req"}, imem_req, 1'b1);
      chk({tag, " wait_pc"}, PC, exp_pc);
      step();
    end
    imem_ack = 1'b1;
    instr = v.ins;
    chk({tag, " fetch_req"}, imem_req, 1'b1);
    chk({tag, " fetch_pc"}, PC, exp_pc);
    chk({tag, " fetch_zero"}, {rs1, rs2, rd, ImmOp, ALUSrc, ALUctrl, RegWrite, instr_done,
                               illegal}, 64'd0);
    step();
    // DECODE
    imem_ack = 1'b0;
    instr = $urandom();
    EQ = v.eq;
    chk({tag, " dec_req"}, imem_req, 1'b0);
    chk({tag, " dec_regs"}, {rs1, rs2, rd}, {v.rs1, v.rs2, v.rd});
    chk({tag, " dec_imm"}, ImmOp, v.imm);
    chk({tag, " dec_ctrl"}, {ALUSrc, ALUctrl, RegWrite, instr_done, illegal},
        {v.alusrc, v.aluctrl, 3'b000});
    step();
    // EXECUTE
    imem_ack = 1'b1;
    instr = $urandom();
    chk({tag, " ex_ctrl"}, {imem_req, ALUSrc, ALUctrl, RegWrite, instr_done, illegal},
        {1'b0, v.alusrc, v.aluctrl, 3'b000});
    chk({tag, " ex_imm"}, ImmOp, v.imm);
    step();
    // WRITEBACK
    imem_ack = 1'b0;
    EQ = ~v.eq;
    chk({tag, " wb_regs"}, {rs1, rs2, rd}, {v.rs1, v.rs2, v.rd});
    chk({tag, " wb_ctrl"}, {ALUSrc, ALUctrl, RegWrite, instr_done, illegal},
        {v.alusrc, v.aluctrl, v.regwrite, 1'b1, v.ill});
    chk({tag, " wb_pc"}, PC, exp_pc);
    step();
    exp_pc = exp_pc + v.off;
    chk({tag, " next_pc"}, PC, exp_pc);
    chk({tag, " next_outs"}, {imem_req, RegWrite, instr_done, illegal}, 4'b1000);
  endtask

  initial begin
    //                ins           eq    w  rs1 rs2 rd  imm           src ctrl rw ill off
    tbl[0] = mk(32'h0070_0293, 1'b0, 0, 0,  7,  5,  32'd7,        1, 3'd0, 1, 0, 32'd4);
    tbl[1] = mk(32'h0020_81B3, 1'b0, 3, 1,  2,  3,  32'd0,        0, 3'd0, 1, 0, 32'd4);
    tbl[2] = mk(32'h0020_8033, 1'b0, 0, 1,  2,  0,  32'd0,        0, 3'd0, 0, 0, 32'd4);
    tbl[3] = mk(32'hFFFF_FFFF, 1'b0, 1, 31, 31, 31, 32'd0,        0, 3'd0, 0, 1, 32'd4);
    tbl[4] = mk(32'h0000_0013, 1'b0, 0, 0,  0,  0,  32'd0,        1, 3'd0, 0, 0, 32'd4);
    tbl[5] = mk(32'hFE20_9CE3, 1'b0, 0, 1,  2,  25, 32'hFFFF_FFF8, 0, 3'd1, 0, 0, 32'hFFFF_FFF8);
    tbl[6] = mk(32'hFFF0_8093, 1'b0, 2, 1,  31, 1,  32'hFFFF_FFFF, 1, 3'd0, 1, 0, 32'd4);
    tbl[7] = mk(32'h0000_0013, 1'b0, 0, 0,  0,  0,  32'd0,        1, 3'd0, 0, 0, 32'd4);
    tbl[8] = mk(32'hFE20_9CE3, 1'b1, 0, 1,  2,  25, 32'hFFFF_FFF8, 0, 3'd1, 0, 0, 32'd4);

    // Reset held two cycles with ack tied high
    rst_n = 1'b0;
    imem_ack = 1'b1;
    step();
    step();
    chk("rst_outs", {imem_req, RegWrite, instr_done, illegal}, 4'b0000);
    chk("rst_pc", PC, RESET_PC);
    chk("rst_fields", {rs1, rs2, rd, ImmOp, ALUSrc, ALUctrl}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_req", imem_req, 1'b1);
    exp_pc = RESET_PC;

    // Directed table: starts at 0xFFFFFFFC so the first ADDI wraps PC to 0
    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i], $sformatf("tbl%0d", i));
    end
    chk("tbl_final_pc", PC, 32'h0000_0014);

    // Reset during WRITEBACK of ADD x3,x1,x2 drops the write and the PC update
    imem_ack = 1'b1;
    instr = 32'h0020_81B3;
    step();
    imem_ack = 1'b0;
    step();
    step();
    chk("abort_wb_regwrite", RegWrite, 1'b1);
    rst_n = 1'b0;
    step();
    chk("abort_regwrite", RegWrite, 1'b0);
    chk("abort_pc", PC, RESET_PC);
    chk("abort_outs", {imem_req, instr_done, illegal}, 3'b000);
    rst_n = 1'b1;
    #1;
    chk("abort_fetch_req", imem_req, 1'b1);
    exp_pc = RESET_PC;

    // Random stream against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 4))
        0: begin w[6:0] = 7'b0110011; w[14:12] = 3'd0; w[31:25] = 7'd0; end
        1: begin w[6:0] = 7'b0010011; w[14:12] = 3'd0; end
        2: begin w[6:0] = 7'b1100011; w[14:12] = 3'd1; end
        3: begin w[6:0] = 7'b0110011; w[14:12] = 3'd0; w[31:25] = 7'b0100000; end
        default: ;
      endcase
      run_instr(model(w, 1'($urandom_range(0, 1)), $urandom_range(0, 2)),
                $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer for the reduced RISC-V register-file / ALU / ALU-operand-mux datapath. It fetches one instruction at a time over a req/ack handshake and decodes ADD, ADDI and BNE. It then drives the register-file addresses, immediate, ALUSrc, ALUctrl and RegWrite over fixed execute/writeback cycles, and owns the program counter. It sits above the regfile + ALU + mux top level and is the only block that writes the PC.

## Interface
Parameters:
- Data_Width, 32, datapath and instruction width
- Addr_Width, 5, register-file address width
- Reset_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous and active-low
- imem_req  output  1  instruction fetch request
- imem_ack  input  1  fetch acknowledge; instr valid in same cycle
- instr  input  Data_Width  instruction word from memory
- PC  output  Data_Width  current program counter (fetch address)
- rs1, rs2, rd  output  Addr_Width  register-file read/write addresses
- ImmOp  output  Data_Width  sign-extended immediate to ALU mux
- ALUSrc  output  1  mux select: 1 = ImmOp, 0 = regOp2
- ALUctrl  output  3  000 = ADD, 001 = SUB
- EQ  input  1  ALU zero flag (operands equal)
- RegWrite  output  1  register-file write enable
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal  output  1  one-cycle pulse when an unsupported opcode retires

## Operation
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK; transitions in that order, WRITEBACK → FETCH.
- FETCH: imem_req=1. Stay while imem_ack=0. On an edge with imem_ack=1, latch instr into IR and move to DECODE. imem_req drops the cycle after ack.
- DECODE: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7]. ImmOp is I-type (IR[31:20]) for ADDI and B-type ({IR[31],IR[7],IR[30:25],IR[11:8],0}) for BNE, sign-extended to Data_Width. The immediate is 0 otherwise.
- Decode rules:
  - ADD: opcode 0110011, f3 000, f7 0000000
  - ADDI: opcode 0010011, f3 000
  - BNE: opcode 1100011, f3 001
  - Anything else is illegal.
- EXECUTE:
  - ADD: ALUSrc=0, ALUctrl=000
  - ADDI: ALUSrc=1, ALUctrl=000
  - BNE: ALUSrc=0, ALUctrl=001; EQ sampled at the end-of-state edge, taken = !EQ.
- WRITEBACK:
  - RegWrite=1 for ADD/ADDI when rd≠0; otherwise 0.
  - instr_done=1. illegal=1 if illegal.
  - PC updates at the exiting edge: PC+ImmOp if BNE taken, else PC+4. Arithmetic is modulo 2^Data_Width, so wrap-around is silent.
- rs1/rs2/rd/ImmOp/ALUSrc/ALUctrl hold stable from DECODE through WRITEBACK.
- Illegal instruction: no register write, PC+4, illegal pulse.

## Timing
- Reset (rst_n=0 at an edge): state=FETCH, PC=Reset_PC, IR=0. All outputs are 0 except PC. imem_req=1 from the first cycle with rst_n=1.
- Reset asserted mid-instruction aborts it. RegWrite is 0 from the next cycle, and a pending PC update is discarded.
- Latency: 4 cycles per instruction with zero-wait ack (ack in first FETCH cycle); +1 per wait cycle.
- Control outputs are pure functions of registered state/IR (Moore). There is no combinational path from EQ or imem_ack to any output.
- imem_ack outside FETCH is ignored.
- The datapath write at the WRITEBACK edge and the PC update occur on the same edge. The next FETCH uses the updated PC.

## Structure
- Package alu_seq_pkg:
  - state enum
  - opcode/funct3/funct7 constants
  - ALUctrl encodings (ALU_ADD=3'b000, ALU_SUB=3'b001)
- Sub-module imm_gen: combinational I-type/B-type extraction and sign extension from IR and the decoded instruction kind.
- Top: FSM, IR, PC register and output decode.

## Test plan
- Reset then fetch: hold rst_n=0 2 cycles, release with imem_ack tied 1 → imem_req=1 first cycle, PC=0. After FETCH, rs1/rs2/rd/ImmOp/ALUSrc/ALUctrl/RegWrite are all 0 until DECODE.
- ADDI x5,x0,7 (0x00700293), zero-wait → DECODE rd=5, ImmOp=7; EXECUTE ALUSrc=1, ALUctrl=000; WRITEBACK RegWrite=1, instr_done=1; PC=4 after 4 cycles.
- BNE x1,x2,-8 (0xFE209CE3) at PC=0x10: EQ=0 gives PC=0x08 with RegWrite=0. EQ=1 gives PC=0x14.
- Fetch wait: imem_ack low 3 cycles then high → imem_req held 4 cycles, instruction retires on cycle 7. An ack pulse injected during EXECUTE has no effect.
- Illegal (0xFFFFFFFF) and ADD x0,x1,x2 → illegal pulse then PC+4 with RegWrite=0. For ADD with rd=0, RegWrite=0 and illegal=0.
- Reset asserted in WRITEBACK of ADD x3,x1,x2 → next cycle RegWrite=0, PC=Reset_PC, state FETCH. PC=0xFFFFFFFC with ADDI wraps to 0.
